// File: rtl/alarm_pkg.sv
// Shared encodings and widths for the alarm LED controller.
package alarm_pkg;

  localparam int STATE_W  = 2;
  localparam int SNOOZE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 2'd0,
    ST_RING   = 2'd1,
    ST_SNOOZE = 2'd2
  } state_t;

endpackage

// File: rtl/sec_tick_gen.sv
// One-cycle tick every CLK_HZ clocks; clr restarts the count so the next
// tick is a full second away.
module sec_tick_gen #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] LAST = PW'(CLK_HZ - 1);

  logic [PW-1:0] presc;

  assign tick = (presc == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      presc <= '0;
    else if (clr || tick)
      presc <= '0;
    else
      presc <= presc + PW'(1);
  end

endmodule

// File: rtl/alarm_led_ctrl.sv
// Alarm sequencer: rings, auto-snoozes, gates the breathing LED and buzzer.
// BUZZ_PATTERN_EN: buzzer pulses 1 s on / 1 s off in RING instead of steady on.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for alarm_trig; LED, buzzer off, breath held
// ST_RING   | LED follows pwm_in, buzzer on, auto-snooze after RING_S
// ST_SNOOZE | quiet; re-ring after SNOOZE_S unless stopped
module alarm_led_ctrl
  import alarm_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int RING_S     = 30,
  parameter int SNOOZE_S   = 300,
  parameter int MAX_SNOOZE = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                alarm_trig,
  input  logic                stop_btn,
  input  logic                snooze_btn,
  input  logic                pwm_in,
  output logic                breath_rst_n,
  output logic                led_out,
  output logic                buzzer_en,
  output logic [STATE_W-1:0]  state,
  output logic [SNOOZE_W-1:0] snooze_cnt
);

  localparam int SEC_MAX = (RING_S > SNOOZE_S) ? RING_S : SNOOZE_S;
  localparam int SEC_W   = $clog2(SEC_MAX + 1);
  localparam logic [SEC_W-1:0]    SEC_TOP     = SEC_W'(SEC_MAX);
  localparam logic [SEC_W-1:0]    RING_LAST   = SEC_W'(RING_S - 1);
  localparam logic [SEC_W-1:0]    SNOOZE_LAST = SEC_W'(SNOOZE_S - 1);
  localparam logic [SNOOZE_W-1:0] SNZ_LIMIT   = SNOOZE_W'(MAX_SNOOZE);

  state_t              state_q, state_d;
  logic [SNOOZE_W-1:0] snz_q, snz_d;
  logic [SEC_W-1:0]    sec_q, sec_d;
  logic                tick, clr, at_limit, timeout;
  logic                ring_d, buzz_on;

  sec_tick_gen #(
    .CLK_HZ(CLK_HZ)
  ) u_sec_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr),
    .tick (tick)
  );

  always_comb begin
    state_d  = state_q;
    snz_d    = snz_q;
    at_limit = (state_q == ST_RING) ? (sec_q == RING_LAST) : (sec_q == SNOOZE_LAST);
    timeout  = tick && at_limit;

    case (state_q)
      ST_IDLE: begin
        if (alarm_trig) begin
          state_d = ST_RING;
          snz_d   = '0;
        end
      end
      ST_RING: begin
        if (stop_btn) begin
          state_d = ST_IDLE;
        end else if (snooze_btn || timeout) begin
          if (snz_q == SNZ_LIMIT) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_SNOOZE;
            snz_d   = snz_q + SNOOZE_W'(1);
          end
        end
      end
      ST_SNOOZE: begin
        if (stop_btn)
          state_d = ST_IDLE;
        else if (timeout)
          state_d = ST_RING;
      end
      default: state_d = ST_IDLE;
    endcase

    // Prescaler and seconds both restart on any state change.
    clr = (state_d != state_q);
    if (clr || state_q == ST_IDLE)
      sec_d = '0;
    else if (tick && sec_q != SEC_TOP)
      sec_d = sec_q + SEC_W'(1);
    else
      sec_d = sec_q;

    ring_d = (state_d == ST_RING);
  end

`ifdef BUZZ_PATTERN_EN
  assign buzz_on = ~sec_d[0];
`else
  assign buzz_on = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      snz_q   <= '0;
      sec_q   <= '0;
    end else begin
      state_q <= state_d;
      snz_q   <= snz_d;
      sec_q   <= sec_d;
    end
  end

  // Outputs registered from next-state so they line up with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      breath_rst_n <= 1'b0;
      led_out      <= 1'b0;
      buzzer_en    <= 1'b0;
    end else begin
      breath_rst_n <= ring_d;
      led_out      <= ring_d & pwm_in;
      buzzer_en    <= ring_d & buzz_on;
    end
  end

  assign state      = state_q;
  assign snooze_cnt = snz_q;

endmodule

// File: tb/tb_alarm_led_ctrl.sv
// Self-checking bench for alarm_led_ctrl: directed vector table, timeout
// chain, reset abandonment and randomized traffic against a cycle model.
module tb_alarm_led_ctrl;

  localparam int CLK_HZ     = 10;
  localparam int RING_S     = 3;
  localparam int SNOOZE_S   = 2;
  localparam int MAX_SNOOZE = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       alarm_trig = 1'b0, stop_btn = 1'b0, snooze_btn = 1'b0, pwm_in = 1'b0;
  logic       breath_rst_n, led_out, buzzer_en;
  logic [1:0] state, snooze_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: state code, snoozes, cycles spent in current state, LED
  int m_state, m_cnt, m_cyc;
  bit m_led;

  alarm_led_ctrl #(
    .CLK_HZ(CLK_HZ), .RING_S(RING_S), .SNOOZE_S(SNOOZE_S), .MAX_SNOOZE(MAX_SNOOZE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .alarm_trig(alarm_trig), .stop_btn(stop_btn),
    .snooze_btn(snooze_btn), .pwm_in(pwm_in), .breath_rst_n(breath_rst_n),
    .led_out(led_out), .buzzer_en(buzzer_en), .state(state), .snooze_cnt(snooze_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int exp_buzz(input int cyc_in_ring);
`ifdef BUZZ_PATTERN_EN
    return ((cyc_in_ring / CLK_HZ) % 2 == 0) ? 1 : 0;
`else
    return 1;
`endif
  endfunction

  task automatic model_reset();
    m_state = 0; m_cnt = 0; m_cyc = 0; m_led = 0;
  endtask

  task automatic model_step(input bit trig, input bit stop, input bit snz, input bit pwm);
    int nstate, limit;
    bit to;
    nstate = m_state;
    limit  = (m_state == 1) ? RING_S * CLK_HZ : SNOOZE_S * CLK_HZ;
    to     = (m_state != 0) && (m_cyc == limit - 1);
    case (m_state)
      0: if (trig) begin nstate = 1; m_cnt = 0; end
      1: if (stop) nstate = 0;
         else if (snz || to) begin
           if (m_cnt == MAX_SNOOZE) nstate = 0;
           else begin nstate = 2; m_cnt++; end
         end
      default: if (stop) nstate = 0; else if (to) nstate = 1;
    endcase
    m_led = (nstate == 1) && pwm;
    m_cyc = (nstate != m_state) ? 0 : m_cyc + 1;
    m_state = nstate;
  endtask

  task automatic check_model(input string tag);
    chk({tag, " state"},  int'(state), m_state);
    chk({tag, " cnt"},    int'(snooze_cnt), m_cnt);
    chk({tag, " breath"}, int'(breath_rst_n), (m_state == 1) ? 1 : 0);
    chk({tag, " led"},    int'(led_out), int'(m_led));
    chk({tag, " buzz"},   int'(buzzer_en), (m_state == 1) ? exp_buzz(m_cyc) : 0);
  endtask

  task automatic cycle(input bit trig, input bit stop, input bit snz, input bit pwm, input string tag);
    alarm_trig = trig; stop_btn = stop; snooze_btn = snz; pwm_in = pwm;
    @(posedge clk);
    model_step(trig, stop, snz, pwm);
    #1;
    check_model(tag);
    alarm_trig = 0; stop_btn = 0; snooze_btn = 0;
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 1'($urandom_range(0, 1)), tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; alarm_trig = 0; stop_btn = 0; snooze_btn = 0; pwm_in = 0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  typedef struct {
    bit trig, stop, snz, pwm;
    int st, cnt, led;
  } vec_t;

  vec_t vecs[13];

  initial begin
    vecs[0]  = '{1, 0, 0, 0, 1, 0, 0};
    vecs[1]  = '{0, 0, 0, 1, 1, 0, 1};
    vecs[2]  = '{0, 0, 0, 0, 1, 0, 0};
    vecs[3]  = '{0, 0, 1, 1, 2, 1, 0};
    vecs[4]  = '{0, 0, 1, 0, 2, 1, 0};
    vecs[5]  = '{1, 0, 0, 0, 2, 1, 0};
    vecs[6]  = '{0, 1, 0, 0, 0, 1, 0};
    vecs[7]  = '{0, 1, 1, 0, 0, 1, 0};
    vecs[8]  = '{0, 0, 1, 0, 0, 1, 0};
    vecs[9]  = '{1, 0, 0, 1, 1, 0, 1};
    vecs[10] = '{0, 1, 1, 0, 0, 0, 0};
    vecs[11] = '{1, 1, 0, 0, 1, 0, 0};
    vecs[12] = '{1, 0, 1, 0, 2, 1, 0};

    model_reset();
    #1;
    chk("reset state",  int'(state), 0);
    chk("reset cnt",    int'(snooze_cnt), 0);
    chk("reset breath", int'(breath_rst_n), 0);
    chk("reset led",    int'(led_out), 0);
    chk("reset buzz",   int'(buzzer_en), 0);
    do_reset();

    // directed vector table
    for (int i = 0; i < 13; i++) begin
      cycle(vecs[i].trig, vecs[i].stop, vecs[i].snz, vecs[i].pwm, "vec");
      chk($sformatf("vec%0d state", i),  int'(state), vecs[i].st);
      chk($sformatf("vec%0d cnt", i),    int'(snooze_cnt), vecs[i].cnt);
      chk($sformatf("vec%0d led", i),    int'(led_out), vecs[i].led);
      chk($sformatf("vec%0d breath", i), int'(breath_rst_n), (vecs[i].st == 1) ? 1 : 0);
      chk($sformatf("vec%0d buzz", i),   int'(buzzer_en), (vecs[i].st == 1) ? 1 : 0);
    end

    // full timeout chain up to forced return to IDLE
    do_reset();
    cycle(1, 0, 0, 0, "chain");
    chk("ring1 entry buzz", int'(buzzer_en), 1);
    for (int k = 1; k < 30; k++) begin
      cycle(0, 0, 0, 1'($urandom_range(0, 1)), "chain");
      if (k == 9 || k == 10 || k == 19 || k == 20)
        chk($sformatf("buzz pattern cyc%0d", k), int'(buzzer_en),
`ifdef BUZZ_PATTERN_EN
            (k >= 10 && k < 20) ? 0 : 1);
`else
            1);
`endif
    end
    chk("ring1 last cycle", int'(state), 1);
    run(1, "chain");
    chk("snooze1 state", int'(state), 2);
    chk("snooze1 cnt", int'(snooze_cnt), 1);
    run(19, "chain");
    chk("snooze1 last cycle", int'(state), 2);
    run(1, "chain");
    chk("ring2 state", int'(state), 1);
    run(29, "chain");
    chk("ring2 last cycle", int'(state), 1);
    run(1, "chain");
    chk("snooze2 state", int'(state), 2);
    chk("snooze2 cnt", int'(snooze_cnt), 2);
    run(20, "chain");
    chk("ring3 state", int'(state), 1);
    run(29, "chain");
    chk("ring3 last cycle", int'(state), 1);
    run(1, "chain");
    chk("forced idle state", int'(state), 0);
    chk("forced idle cnt", int'(snooze_cnt), 2);

    // stop and snooze together in RING with a nonzero snooze count
    cycle(1, 0, 0, 0, "both");
    cycle(0, 0, 1, 0, "both");
    run(20, "both");
    chk("both pre state", int'(state), 1);
    cycle(0, 1, 1, 1, "both");
    chk("both state", int'(state), 0);
    chk("both cnt", int'(snooze_cnt), 1);

    // async reset mid-SNOOZE
    cycle(1, 0, 0, 0, "rst");
    cycle(0, 0, 1, 0, "rst");
    run(5, "rst");
    #2 rst_n = 0;
    model_reset();
    #1;
    chk("rst snooze state", int'(state), 0);
    chk("rst snooze cnt", int'(snooze_cnt), 0);
    @(negedge clk);
    rst_n = 1;
    run(3, "rst post");
    chk("rst post idle", int'(state), 0);
    cycle(1, 0, 0, 1, "rst restart");
    chk("rst restart state", int'(state), 1);
    chk("rst restart cnt", int'(snooze_cnt), 0);

    // async reset mid-RING with LED, buzzer, breath all active
    cycle(0, 0, 0, 1, "rst ring");
    chk("rst ring pre led", int'(led_out), 1);
    #2 rst_n = 0;
    model_reset();
    #1;
    chk("rst ring led", int'(led_out), 0);
    chk("rst ring buzz", int'(buzzer_en), 0);
    chk("rst ring breath", int'(breath_rst_n), 0);
    chk("rst ring state", int'(state), 0);
    @(negedge clk);
    rst_n = 1;
    run(4, "rst ring post");

    // randomized traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      cycle(1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 59) == 0),
            1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
